// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and address helper for the SRAM-backed MEM stage.
package mem_pkg;

   localparam int unsigned SRAM_BASE     = 1024;
   localparam int unsigned SRAM_ADDR_W   = 18;
   localparam int unsigned SRAM_DATA_W   = 16;
   localparam int unsigned SRAM_WAIT_DEF = 2;

   // One 32-bit word occupies two consecutive 16-bit SRAM locations.
   localparam int unsigned WORD_IDX_W = SRAM_ADDR_W - 1;

   typedef enum logic [1:0] {
      StIdle,
      StLow,
      StHigh,
      StDone
   } mem_state_e;

   // Byte address to word index relative to the SRAM window; wraps modulo 2^WORD_IDX_W.
   function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] byte_addr);
      logic [31:0] off;
      off = byte_addr - SRAM_BASE;
      return WORD_IDX_W'(off >> 2);
   endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// External 16-bit SRAM bus: the MEM stage is the master, the memory device the slave.
interface mem_stage_sram_if;
   import mem_pkg::*;

   logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
   logic                   SRAM_WE_N;
   logic [SRAM_DATA_W-1:0] SRAM_DQ_out;
   logic                   SRAM_DQ_oe;
   logic [SRAM_DATA_W-1:0] SRAM_DQ_in;

   modport master (
      output SRAM_ADDR,
      output SRAM_WE_N,
      output SRAM_DQ_out,
      output SRAM_DQ_oe,
      input  SRAM_DQ_in
   );

   modport slave (
      input  SRAM_ADDR,
      input  SRAM_WE_N,
      input  SRAM_DQ_out,
      input  SRAM_DQ_oe,
      output SRAM_DQ_in
   );

endinterface

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage backed by a 16-bit external SRAM. Each 32-bit load/store is split into a
// low-half and a high-half access, each held for SRAM_WAIT cycles, while the pipeline is frozen.
module mem_stage_sram
   import mem_pkg::*;
#(
   parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 WB_en_in,
   input  logic                 MEM_R_en_in,
   input  logic                 MEM_W_en_in,
   input  logic [31:0]          ALU_result_in,
   input  logic [31:0]          Val_Rm_in,
   input  logic [3:0]           Dest_in,
   output logic                 WB_en,
   output logic                 MEM_R_en,
   output logic [31:0]          ALU_result,
   output logic [31:0]          Mem_read_value,
   output logic [3:0]           Dest,
   output logic                 ready,
   mem_stage_sram_if.master     sram
);

   localparam int unsigned    CNT_W    = $clog2(SRAM_WAIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

   mem_state_e             state;
   logic [CNT_W-1:0]       wait_cnt;
   logic [WORD_IDX_W-1:0]  idx;
   logic [31:0]            wdata;
   logic                   op_store;
   // Only the low half needs buffering: the high half arrives in the same cycle the
   // assembled word is written to read_value.
   logic [SRAM_DATA_W-1:0] rd_buf_lo;
   logic [31:0]            read_value;

   logic req;
   logic last_wait;

   assign req       = MEM_R_en_in | MEM_W_en_in;
   assign last_wait = (wait_cnt == CNT_LAST);

   // FSM, wait counter, request capture and load data assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         wait_cnt   <= '0;
         idx        <= '0;
         wdata      <= '0;
         op_store   <= 1'b0;
         rd_buf_lo  <= '0;
         read_value <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (req) begin
                  idx      <= word_index(ALU_result_in);
                  wdata    <= Val_Rm_in;
                  // A simultaneous read and write request is treated as a store.
                  op_store <= MEM_W_en_in;
                  wait_cnt <= '0;
                  state    <= StLow;
               end
            end
            StLow: begin
               if (last_wait) begin
                  if (!op_store) begin
                     rd_buf_lo <= sram.SRAM_DQ_in;
                  end
                  wait_cnt <= '0;
                  state    <= StHigh;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StHigh: begin
               if (last_wait) begin
                  if (!op_store) begin
                     read_value <= {sram.SRAM_DQ_in, rd_buf_lo};
                  end
                  wait_cnt <= '0;
                  state    <= StDone;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // Pipeline pass-through and stall signalling; write-back is suppressed while frozen.
   always_comb begin
      ready          = (state == StDone) || ((state == StIdle) && !req);
      WB_en          = WB_en_in & ready;
      MEM_R_en       = MEM_R_en_in;
      ALU_result     = ALU_result_in;
      Dest           = Dest_in;
      Mem_read_value = read_value;
   end

   // SRAM bus decoded from the registered state, address and store data.
   always_comb begin
      sram.SRAM_ADDR   = '0;
      sram.SRAM_WE_N   = 1'b1;
      sram.SRAM_DQ_out = '0;
      sram.SRAM_DQ_oe  = 1'b0;
      unique case (state)
         StLow: begin
            sram.SRAM_ADDR = {idx, 1'b0};
            if (op_store) begin
               sram.SRAM_WE_N   = 1'b0;
               sram.SRAM_DQ_oe  = 1'b1;
               sram.SRAM_DQ_out = wdata[15:0];
            end
         end
         StHigh: begin
            sram.SRAM_ADDR = {idx, 1'b1};
            if (op_store) begin
               sram.SRAM_WE_N   = 1'b0;
               sram.SRAM_DQ_oe  = 1'b1;
               sram.SRAM_DQ_out = wdata[31:16];
            end
         end
         default: ;
      endcase
   end

   // Write strobe must never be asserted without driving the data bus.
   a_we_has_oe : assert property (@(posedge clk) disable iff (rst)
      !sram.SRAM_WE_N |-> sram.SRAM_DQ_oe);

   // The completion state lasts exactly one cycle.
   a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
      (state == StDone) |=> (state == StIdle));

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomised bench for mem_stage_sram with a behavioural SRAM and a word-level reference model.
module tb_mem_stage_sram;

   localparam int unsigned W      = 2;
   localparam int          FREEZE = 1 + 2 * W;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_en_in;
   logic        MEM_R_en_in;
   logic        MEM_W_en_in;
   logic [31:0] ALU_result_in;
   logic [31:0] Val_Rm_in;
   logic [3:0]  Dest_in;
   logic        WB_en;
   logic        MEM_R_en;
   logic [31:0] ALU_result;
   logic [31:0] Mem_read_value;
   logic [3:0]  Dest;
   logic        ready;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_sram_if sram ();

   mem_stage_sram #(.SRAM_WAIT(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .WB_en_in       (WB_en_in),
      .MEM_R_en_in    (MEM_R_en_in),
      .MEM_W_en_in    (MEM_W_en_in),
      .ALU_result_in  (ALU_result_in),
      .Val_Rm_in      (Val_Rm_in),
      .Dest_in        (Dest_in),
      .WB_en          (WB_en),
      .MEM_R_en       (MEM_R_en),
      .ALU_result     (ALU_result),
      .Mem_read_value (Mem_read_value),
      .Dest           (Dest),
      .ready          (ready),
      .sram           (sram)
   );

   always #5 clk = ~clk;

   // sram_model: asynchronous read, write on the clock edge while WE_N is low.
   logic [15:0] sram_mem [0:4095];
   always @(posedge clk) begin : sram_model
      if (!sram.SRAM_WE_N) begin
         sram_mem[sram.SRAM_ADDR[11:0]] <= sram.SRAM_DQ_oe ? sram.SRAM_DQ_out : 16'hFFFF;
      end
   end
   assign sram.SRAM_DQ_in = sram_mem[sram.SRAM_ADDR[11:0]];

   // Reference model: 32-bit words keyed by word index, plus the last loaded value.
   logic [31:0] ref_mem [int];
   logic [31:0] ref_rd;

   function automatic int word_of(input logic [31:0] a);
      return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
   endfunction

   function automatic logic [31:0] ref_word(input int w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one instruction for a cycle after the next rising edge, follow the freeze and
   // check the bus activity and forwarded values in the cycle where ready is high.
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic wb,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] dst);
      int          stalls;
      int          we_cycles;
      int          phase;
      int          w;
      bit          bus_ok;
      logic [17:0] exp_addr;
      logic [15:0] exp_dq;
      stalls    = 0;
      we_cycles = 0;
      bus_ok    = 1'b1;
      w         = word_of(addr);
      @(posedge clk);
      #1;
      MEM_R_en_in   = rd;
      MEM_W_en_in   = wr;
      WB_en_in      = wb;
      ALU_result_in = addr;
      Val_Rm_in     = data;
      Dest_in       = dst;
      @(negedge clk);
      while (!ready && stalls < 4 * FREEZE) begin
         if (WB_en !== 1'b0) bus_ok = 1'b0;
         if (stalls >= 1) begin
            phase    = (stalls - 1) / int'(W);
            exp_addr = 18'(w * 2 + phase);
            exp_dq   = (phase == 1) ? data[31:16] : data[15:0];
            if (sram.SRAM_ADDR !== exp_addr) bus_ok = 1'b0;
            if (wr) begin
               if (sram.SRAM_WE_N !== 1'b0 || sram.SRAM_DQ_oe !== 1'b1 ||
                   sram.SRAM_DQ_out !== exp_dq) bus_ok = 1'b0;
            end else if (sram.SRAM_WE_N !== 1'b1 || sram.SRAM_DQ_oe !== 1'b0) begin
               bus_ok = 1'b0;
            end
         end else if (sram.SRAM_WE_N !== 1'b1 || sram.SRAM_DQ_oe !== 1'b0) begin
            bus_ok = 1'b0;
         end
         if (sram.SRAM_WE_N === 1'b0) we_cycles++;
         stalls++;
         @(negedge clk);
      end
      if (sram.SRAM_WE_N !== 1'b1 || sram.SRAM_DQ_oe !== 1'b0) bus_ok = 1'b0;
      if (wr) ref_mem[w] = data;
      else if (rd) ref_rd = ref_word(w);
      check_eq({tag, ".freeze"}, stalls, (rd | wr) ? FREEZE : 0);
      check_eq({tag, ".we_cycles"}, we_cycles, wr ? 2 * W : 0);
      check_eq({tag, ".bus"}, 32'(bus_ok), 32'd1);
      check_eq({tag, ".rd_val"}, Mem_read_value, ref_rd);
      check_eq({tag, ".wb_en"}, 32'(WB_en), 32'(wb));
      check_eq({tag, ".dest"}, 32'(Dest), 32'(dst));
      check_eq({tag, ".alu"}, ALU_result, addr);
      check_eq({tag, ".mem_r_en"}, 32'(MEM_R_en), 32'(rd));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int          kind;
      int          cnt_we;
      int          cnt_stall;
      logic [31:0] a;
      rst           = 1'b1;
      WB_en_in      = 1'b0;
      MEM_R_en_in   = 1'b0;
      MEM_W_en_in   = 1'b0;
      ALU_result_in = '0;
      Val_Rm_in     = '0;
      Dest_in       = '0;
      ref_rd        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset.ready", 32'(ready), 32'd1);
      check_eq("reset.we_n", 32'(sram.SRAM_WE_N), 32'd1);
      check_eq("reset.oe", 32'(sram.SRAM_DQ_oe), 32'd0);
      check_eq("reset.rd_val", Mem_read_value, 32'h0);
      check_eq("reset.wb_en", 32'(WB_en), 32'd0);
      rst = 1'b0;

      // Give every word in the random address window a known value.
      for (int i = 0; i < 64; i++) begin
         run_op("fill", 1'b0, 1'b1, 1'b0, 32'(1024 + 4 * i), $urandom, 4'(i));
      end

      run_op("st1028", 1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd3);
      check_eq("st1028.sram_lo", 32'(sram_mem[2]), 32'h0000BEEF);
      check_eq("st1028.sram_hi", 32'(sram_mem[3]), 32'h0000DEAD);
      run_op("ld1028", 1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd7);
      check_eq("ld1028.value", Mem_read_value, 32'hDEADBEEF);
      run_op("alu5", 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 4'd5);
      run_op("b2b_ld1032", 1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd8);
      run_op("b2b_st1032", 1'b0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 4'd9);
      run_op("b2b_chk1032", 1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd10);
      run_op("both1024", 1'b1, 1'b1, 1'b1, 32'd1024, 32'h0BADC0DE, 4'd2);

      for (int i = 0; i < 120; i++) begin
         kind = int'($urandom_range(0, 9));
         a    = 32'(1024 + 4 * $urandom_range(0, 63));
         if (kind < 3) begin
            run_op("rnd_alu", 1'b0, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end else if (kind < 6) begin
            run_op("rnd_ld", 1'b1, 1'b0, 1'($urandom), a, $urandom, 4'($urandom));
         end else if (kind < 9) begin
            run_op("rnd_st", 1'b0, 1'b1, 1'($urandom), a, $urandom, 4'($urandom));
         end else begin
            run_op("rnd_both", 1'b1, 1'b1, 1'($urandom), a, $urandom, 4'($urandom));
         end
      end

      // Reset in the middle of the high half of a store to a word outside the random window.
      run_op("pre_rst_ld", 1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 4'd1);
      @(posedge clk);
      #1;
      MEM_R_en_in   = 1'b0;
      MEM_W_en_in   = 1'b1;
      WB_en_in      = 1'b0;
      ALU_result_in = 32'(1024 + 4 * 900);
      Val_Rm_in     = 32'h5A5AA5A5;
      @(negedge clk);
      repeat (W + 1) @(negedge clk);
      check_eq("rst.in_high_addr", 32'(sram.SRAM_ADDR), 32'd1801);
      check_eq("rst.in_high_we_n", 32'(sram.SRAM_WE_N), 32'd0);
      rst         = 1'b1;
      MEM_W_en_in = 1'b0;
      @(negedge clk);
      check_eq("rst.ready", 32'(ready), 32'd1);
      check_eq("rst.we_n", 32'(sram.SRAM_WE_N), 32'd1);
      check_eq("rst.oe", 32'(sram.SRAM_DQ_oe), 32'd0);
      check_eq("rst.rd_val", Mem_read_value, 32'h0);
      rst    = 1'b0;
      ref_rd = '0;
      cnt_we    = 0;
      cnt_stall = 0;
      for (int i = 0; i < 2 * FREEZE; i++) begin
         @(negedge clk);
         if (sram.SRAM_WE_N === 1'b0) cnt_we++;
         if (ready !== 1'b1) cnt_stall++;
      end
      check_eq("rst.no_retry_we", cnt_we, 0);
      check_eq("rst.no_retry_stall", cnt_stall, 0);
      run_op("post_rst_ld", 1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd4);

      @(posedge clk);
      #1;
      MEM_R_en_in = 1'b0;
      MEM_W_en_in = 1'b0;
      WB_en_in    = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 Parameter SRAM_WAIT, default 2; number of clock cycles each 16-bit SRAM half-access is held.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 WB_en_in  in  1  write-back enable from the EXE stage register.
REQ-005 MEM_R_en_in  in  1  load request.
REQ-006 MEM_W_en_in  in  1  store request.
REQ-007 ALU_result_in  in  32  byte address for loads/stores; pass-through value otherwise.
REQ-008 Val_Rm_in  in  32  store data.
REQ-009 Dest_in  in  4  destination register index.
REQ-010 WB_en, MEM_R_en  out  1  forwarded to the MEM stage register.
REQ-011 ALU_result  out  32  forwarded ALU result.
REQ-012 Mem_read_value  out  32  assembled load data.
REQ-013 Dest  out  4  forwarded destination index.
REQ-014 ready  out  1  high = stage may advance; the pipeline freeze is ~ready.
REQ-015 SRAM_ADDR  out  18  halfword address to the external SRAM.
REQ-016 SRAM_WE_N  out  1  active-low SRAM write strobe.
REQ-017 SRAM_DQ_out  out  16  write data.
REQ-018 SRAM_DQ_oe  out  1  drive enable for SRAM_DQ_out.
REQ-019 SRAM_DQ_in  in  16  read data from the SRAM.

Function
REQ-020 FSM states: IDLE, LOW, HIGH, DONE.
REQ-021 In IDLE with no request, the block SHALL hold ready=1 and pass MEM_R_en, ALU_result and Dest through combinationally.
REQ-022 In IDLE with MEM_R_en_in or MEM_W_en_in set:
  - ready=0;
  - word index = (ALU_result_in - 1024) >> 2, truncated to 17 bits (modulo wrap);
  - register the word index, Val_Rm_in and the op type;
  - clear the wait counter;
  - next state LOW.
REQ-023 When MEM_W_en_in and MEM_R_en_in are both set, the operation SHALL be a store and Mem_read_value SHALL remain unchanged.
REQ-024 In LOW, for SRAM_WAIT cycles: SRAM_ADDR={idx,1'b0}; ready=0.
  - Store: SRAM_WE_N=0, SRAM_DQ_oe=1, SRAM_DQ_out=data[15:0].
  - Load: on the last cycle, latch SRAM_DQ_in into read buffer [15:0].
  - Then go to HIGH.
REQ-025 HIGH is identical to LOW except SRAM_ADDR={idx,1'b1}, data[31:16], buffer [31:16]; then go to DONE.
REQ-026 DONE lasts one cycle: ready=1; Mem_read_value valid (loads); next state IDLE unconditionally.
REQ-027 Total freeze per memory op SHALL be 1+2*SRAM_WAIT cycles (5 at default), with ready=1 in the following DONE cycle.
REQ-028 WB_en SHALL equal WB_en_in AND ready, so no write-back is issued during a stall.
REQ-029 Mem_read_value SHALL be registered and hold its value until the next load completes its HIGH phase.
REQ-030 Outside store phases: SRAM_WE_N=1 and SRAM_DQ_oe=0.
REQ-031 The wait counter width SHALL be $clog2(SRAM_WAIT)+1, and SRAM_WAIT=1 SHALL be legal.
REQ-032 Upstream inputs are held stable while ready=0; the block SHALL use the registered address and data regardless.

Reset
REQ-033 When rst=1 at a clock edge, in any state including mid-operation, the next cycle SHALL show:
  - state IDLE, counter 0;
  - read buffer, Mem_read_value, stored index and data all 0;
  - SRAM_WE_N=1, SRAM_DQ_oe=0, ready=1.
REQ-034 An aborted store SHALL NOT be retried after reset.

Structure
REQ-035 Package mem_pkg SHALL hold:
  - the state enum;
  - SRAM_BASE=1024;
  - SRAM_ADDR_W=18;
  - SRAM_DATA_W=16;
  - the default SRAM_WAIT.
REQ-036 No RTL sub-module: the FSM, counter and buffer SHALL be in one module; the bench SHALL supply a behavioural SRAM model, sram_model.

Verification
REQ-037 Store at ALU_result=1028, Val_Rm=0xDEADBEEF -> SRAM_ADDR=2 with DQ_out=0xBEEF and WE_N=0 for 2 cycles, then SRAM_ADDR=3 with 0xDEAD for 2 cycles; ready=0 for 5 cycles, 1 on the 6th.
REQ-038 Load from 1028 after REQ-037 -> Mem_read_value=0xDEADBEEF in DONE; WB_en=1 only in that cycle.
REQ-039 ALU instruction with no memory enables, WB_en_in=1, Dest_in=5 -> ready stays 1; WB_en=1 and Dest=5 in the same cycle.
REQ-040 Back-to-back load then store at 1032 -> the store enters LOW one cycle after the load's DONE; no overlap of SRAM strobes.
REQ-041 rst asserted during HIGH of a store -> next cycle IDLE, WE_N=1, oe=0, ready=1, Mem_read_value=0.
REQ-042 MEM_R_en_in=MEM_W_en_in=1 at 1024 -> store performed (WE_N pulses), Mem_read_value unchanged.
